present_decrypt: RTL and testbench



---
 rtl/present_pkg.sv | 64 ++++++
 rtl/present_inv_round.sv | 13 +
 rtl/present_decrypt.sv | 101 ++++++++++
 tb/tb_present_decrypt.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, state encoding and the inverse-direction helper functions
// used by the decryption core and its round sub-module.
package present_pkg;

    localparam int KEY_W = 80;
    localparam int BLK_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPAND,
        S_WHITEN,
        S_ROUNDS,
        S_DONE
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [BLK_W-1:0] sbox_inv_layer(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[6'(4*i) +: 4] = SBOX_INV[d[6'(4*i) +: 4]];
        end
        return r;
    endfunction

    // Forward P moves bit j to 16*j mod 63 (bit 63 fixed); undo it by gathering.
    function automatic logic [BLK_W-1:0] p_layer_inv(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) begin
            r[6'(j)] = d[6'((16*j) % 63)];
        end
        r[63] = d[63];
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] key_update_fwd(input logic [KEY_W-1:0] k,
                                                        input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = SBOX[r[79:76]];
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] key_update_inv(input logic [KEY_W-1:0] k,
                                                        input logic [4:0]       rc);
        logic [KEY_W-1:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ rc;
        r[79:76]   = SBOX_INV[r[79:76]];
        return {r[60:0], r[79:61]};
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// One combinational PRESENT inverse round: undo the permutation, undo the S-boxes,
// then strip the round key.
module present_inv_round
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] data_in,
    input  logic [BLK_W-1:0] round_key,
    output logic [BLK_W-1:0] data_out
);

    assign data_out = sbox_inv_layer(p_layer_inv(data_in)) ^ round_key;

endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryptor: expands the key forward to K32, whitens, then runs the
// inverse rounds while stepping the key schedule backwards, one round per clock.
module present_decrypt
    import present_pkg::*;
#(
    parameter int NUM_ROUNDS = 31,
    parameter int COUNTER_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [BLK_W-1:0]  ciphertext,
    output logic              ready,
    output logic              done,
    output logic [BLK_W-1:0]  plaintext
);

    localparam logic [COUNTER_W-1:0] CNT_LAST = COUNTER_W'(NUM_ROUNDS);
    localparam logic [COUNTER_W-1:0] CNT_ONE  = COUNTER_W'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic [KEY_W-1:0]       kreg;
    logic [BLK_W-1:0]       dreg;
    logic [COUNTER_W-1:0]   cnt;
    logic [BLK_W-1:0]       round_out;

    present_inv_round u_inv_round (
        .data_in   (dreg),
        .round_key (kreg[79:16]),
        .data_out  (round_out)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_EXPAND;
            S_EXPAND: if (cnt == CNT_LAST) state_nxt = S_WHITEN;
            S_WHITEN: state_nxt = S_ROUNDS;
            S_ROUNDS: if (cnt == CNT_ONE) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            kreg      <= '0;
            dreg      <= '0;
            cnt       <= '0;
            plaintext <= '0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            ready <= (state_nxt == S_IDLE);
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        kreg <= key;
                        dreg <= ciphertext;
                        cnt  <= CNT_ONE;
                    end
                end
                S_EXPAND: begin
                    kreg <= key_update_fwd(kreg, 5'(cnt));
                    // Counter parks at the last round so it never wraps before WHITEN.
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WHITEN: begin
                    dreg <= dreg ^ kreg[79:16];
                    kreg <= key_update_inv(kreg, 5'(CNT_LAST));
                    cnt  <= CNT_LAST;
                end
                S_ROUNDS: begin
                    dreg <= round_out;
                    if (cnt > CNT_ONE) begin
                        kreg <= key_update_inv(kreg, 5'(cnt - CNT_ONE));
                        cnt  <= cnt - CNT_ONE;
                    end else begin
                        plaintext <= round_out;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_decrypt.sv
// Directed bench for present_decrypt: published PRESENT-80 vectors plus handshake,
// input-isolation, back-to-back and mid-operation reset scenarios.
module tb_present_decrypt;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [79:0]  key;
    logic [63:0]  ciphertext;
    logic         ready;
    logic         done;
    logic [63:0]  plaintext;

    int checks = 0;
    int errors = 0;

    present_decrypt dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .key        (key),
        .ciphertext (ciphertext),
        .ready      (ready),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges after the accept edge until done; -1 if it never arrives.
    task automatic wait_done(output int lat, output int rdy_hi);
        lat    = -1;
        rdy_hi = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (ready !== 1'b0) rdy_hi++;
        end
    endtask

    int lat;
    int rdy_hi;
    int done_seen;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        key        = '0;
        ciphertext = '0;
        tick();
        tick();
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_plaintext", plaintext, 64'h0);
        reset_n = 1'b1;
        tick();

        // Vector 1 with stray starts and input changes during the run
        key        = 80'h0;
        ciphertext = 64'h5579C1387B228445;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("v1_ready_after_accept", 64'(ready), 64'd0);
        lat    = -1;
        rdy_hi = 0;
        for (int n = 1; n <= 100; n++) begin
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
            if (n == 20) begin
                key        = {80{1'b1}};
                ciphertext = 64'hDEADBEEFCAFEF00D;
            end
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (ready !== 1'b0) rdy_hi++;
        end
        check("v1_latency", 64'(lat), 64'd63);
        check("v1_plaintext", plaintext, 64'h0000000000000000);
        check("v1_ready_low_during_run", 64'(rdy_hi), 64'd0);
        check("v1_ready_in_done_cycle", 64'(ready), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("v1_ready_after_done", 64'(ready), 64'd1);
        check("v1_done_pulse_width", 64'(done), 64'd0);
        check("v1_plaintext_held", plaintext, 64'h0000000000000000);
        tick();
        check("v1_start_in_done_ignored", 64'(ready), 64'd1);
        check("v1_no_extra_done", 64'(done), 64'd0);

        // Vector 3 then vector 4 with start held high throughout
        key        = 80'h0;
        ciphertext = 64'hA112FFC72F68417B;
        start      = 1'b1;
        tick();
        wait_done(lat, rdy_hi);
        check("v3_latency", 64'(lat), 64'd63);
        check("v3_plaintext", plaintext, 64'hFFFFFFFFFFFFFFFF);
        key        = {80{1'b1}};
        ciphertext = 64'h3333DCD3213210D2;
        tick();
        check("b2b_ready_idle_cycle", 64'(ready), 64'd1);
        tick();
        check("b2b_accepted", 64'(ready), 64'd0);
        start = 1'b0;
        wait_done(lat, rdy_hi);
        check("v4_latency", 64'(lat), 64'd63);
        check("v4_plaintext", plaintext, 64'hFFFFFFFFFFFFFFFF);
        check("v4_ready_low_during_run", 64'(rdy_hi), 64'd0);
        tick();
        tick();

        // Abort an operation with reset at cycle 30, then run vector 2
        key        = {80{1'b1}};
        ciphertext = 64'hE72C46C0F5945049;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 30; n++) tick();
        reset_n = 1'b0;
        tick();
        check("midreset_ready", 64'(ready), 64'd1);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_plaintext", plaintext, 64'h0);
        reset_n   = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            if (done !== 1'b0) done_seen++;
        end
        check("midreset_no_done_pulse", 64'(done_seen), 64'd0);
        check("midreset_idle_ready", 64'(ready), 64'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, rdy_hi);
        check("v2_latency", 64'(lat), 64'd63);
        check("v2_plaintext", plaintext, 64'h0000000000000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
